// File: rtl/axilite_pkg.sv
// axilite_pkg: AXI-Lite response codes, master state encoding and default widths.
package axilite_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_e;
endpackage

// File: rtl/axilite_m.sv
// axilite_m: single-outstanding AXI-Lite master driven by a local command/response port.
// Define AXILITE_M_TIMEOUT_EN to abort stalled channels after TIMEOUT_CYCLES.
module axilite_m
  import axilite_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp
);
  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              to_q, to_d;
  logic              cmd_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
  logic              expire;

`ifdef AXILITE_M_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy;
  assign busy   = state_q inside {WR_AW_W, WR_B, RD_AR, RD_R};
  assign expire = busy && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign cnt_d  = (state_d != state_q || !busy) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
    if (!m_axi_aresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  // Constant 0: without the timeout build the FSM waits indefinitely.
  assign expire = TIMEOUT_CYCLES < 0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    to_d      = to_q;
    unique case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        wr_d      = cmd_write;
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        rdata_d   = '0;
        resp_d    = RESP_OKAY;
        to_d      = 1'b0;
        state_d   = cmd_write ? WR_AW_W : RD_AR;
      end
      WR_AW_W: begin
        aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
        w_done_d  = w_done_q | (wvalid_q & m_axi_wready);
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: if (m_axi_bvalid && bready_q) begin
        resp_d  = m_axi_bresp;
        state_d = RESP;
      end
      RD_AR: if (arvalid_q && m_axi_arready) state_d = RD_R;
      RD_R: if (m_axi_rvalid && rready_q) begin
        rdata_d = m_axi_rdata;
        resp_d  = m_axi_rresp;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expire) begin
      state_d = RESP;
      to_d    = 1'b1;
      resp_d  = RESP_SLVERR;
      rdata_d = '0;
    end
  end

  // Handshake outputs are registered copies decoded from the next state.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
    if (!m_axi_aresetn) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      to_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      to_q        <= to_d;
      cmd_ready_q <= state_d == IDLE;
      awvalid_q   <= state_d == WR_AW_W && !aw_done_d;
      wvalid_q    <= state_d == WR_AW_W && !w_done_d;
      bready_q    <= state_d == WR_B;
      arvalid_q   <= state_d == RD_AR;
      rready_q    <= state_d == RD_R;
      rsp_valid_q <= state_d == RESP;
    end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = wr_q;
  assign rsp_data      = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = to_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_rready  = rready_q;
endmodule
